// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Memory access size encodings and memory-stage FSM states.
package mips_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // Half needs bit 0 clear, word (and reserved) needs both low bits clear.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] a);
        logic r;
        r = 1'b0;
        if (size == MEM_HALF) begin
            r = a[0];
        end else if (size != MEM_BYTE) begin
            r = |a;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extract/extend for loads.
// Purely combinational; size 11 is handled as a word.
module mem_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_addr_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] wr_data_o,
    output logic [3:0]  byte_en_o,
    input  logic [1:0]  ld_addr_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_sext_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Store: replicate the operand into every lane, enable only the target lanes.
    always_comb begin
        wr_data_o = st_data_i;
        byte_en_o = 4'b1111;
        unique case (st_size_i)
            MEM_BYTE: begin
                wr_data_o = {4{st_data_i[7:0]}};
                byte_en_o = 4'b0001 << st_addr_i;
            end
            MEM_HALF: begin
                wr_data_o = {2{st_data_i[15:0]}};
                byte_en_o = st_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data_o = st_data_i;
                byte_en_o = 4'b1111;
            end
        endcase
    end

    assign ld_b = 8'(rd_data_i >> {ld_addr_i, 3'b000});
    assign ld_h = 16'(rd_data_i >> {ld_addr_i[1], 4'b0000});

    // Load: pick the addressed lane and zero- or sign-extend it.
    always_comb begin
        ld_data_o = rd_data_i;
        unique case (ld_size_i)
            MEM_BYTE: ld_data_o = {{24{ld_sext_i & ld_b[7]}}, ld_b};
            MEM_HALF: ld_data_o = {{16{ld_sext_i & ld_h[15]}}, ld_h};
            default:  ld_data_o = rd_data_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage with MEM/WB register and req/ack data-memory port.
// Holds upstream while an access is outstanding; aborts on ack timeout.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_W = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_Valid,
    input  logic [31:0] ex_AluResult,
    input  logic [31:0] ex_StoreData,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic [1:0]  ex_MemSize,
    input  logic        ex_MemSignExt,
    input  logic        ex_MemRegSel,
    input  logic        ex_RegWriteSel,
    input  logic [4:0]  ex_RegDest,
    output logic [31:0] ext_Addr,
    output logic [31:0] ext_WrData,
    output logic [3:0]  ext_ByteEn,
    output logic        ext_Rd,
    output logic        ext_Wr,
    input  logic        ext_Ack,
    input  logic [31:0] ext_RdData,
    output logic        me_Stall,
    output logic [31:0] me_ExtMemRdData,
    output logic [31:0] me_ByData,
    output logic        me_MemRegSel,
    output logic        me_RegWriteSel,
    output logic [4:0]  me_RegDest,
    output logic        me_AlignErr,
    output logic        me_BusErr
);

    mem_state_e           state_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 ld_q, sext_q, msel_q, regw_q;
    logic [1:0]           size_q;
    logic [31:0]          addr_q;
    logic [4:0]           dest_q;

    logic                 mem_op, misal, start, timeout;
    logic [31:0]          st_data, ld_data;
    logic [3:0]           st_be;

    assign mem_op  = ex_MemRead | ex_MemWrite;
    assign misal   = is_misaligned(ex_MemSize, ex_AluResult[1:0]);
    assign start   = (state_q == ST_IDLE) & ex_Valid & mem_op & ~misal;
    assign timeout = &cnt_q;

    assign me_Stall = start | ((state_q == ST_ACCESS) & ~ext_Ack);

    mem_align u_align (
        .st_addr_i (ex_AluResult[1:0]),
        .st_size_i (ex_MemSize),
        .st_data_i (ex_StoreData),
        .wr_data_o (st_data),
        .byte_en_o (st_be),
        .ld_addr_i (addr_q[1:0]),
        .ld_size_i (size_q),
        .ld_sext_i (sext_q),
        .rd_data_i (ext_RdData),
        .ld_data_o (ld_data)
    );

    // Access FSM, ack-wait counter, external request and MEM/WB registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            ld_q            <= 1'b0;
            sext_q          <= 1'b0;
            msel_q          <= 1'b0;
            regw_q          <= 1'b0;
            size_q          <= MEM_BYTE;
            addr_q          <= '0;
            dest_q          <= '0;
            ext_Rd          <= 1'b0;
            ext_Wr          <= 1'b0;
            ext_Addr        <= '0;
            ext_WrData      <= '0;
            ext_ByteEn      <= '0;
            me_ExtMemRdData <= '0;
            me_ByData       <= '0;
            me_MemRegSel    <= 1'b0;
            me_RegWriteSel  <= 1'b0;
            me_RegDest      <= '0;
            me_AlignErr     <= 1'b0;
            me_BusErr       <= 1'b0;
        end else begin
            me_AlignErr <= 1'b0;
            me_BusErr   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!ex_Valid) begin
                        me_RegWriteSel <= 1'b0;
                    end else if (!mem_op) begin
                        me_ByData      <= ex_AluResult;
                        me_MemRegSel   <= ex_MemRegSel;
                        me_RegWriteSel <= ex_RegWriteSel;
                        me_RegDest     <= ex_RegDest;
                    end else if (misal) begin
                        me_AlignErr    <= 1'b1;
                        me_RegWriteSel <= 1'b0;
                    end else begin
                        state_q        <= ST_ACCESS;
                        cnt_q          <= TIMEOUT_W'(1);
                        ld_q           <= ex_MemRead;
                        sext_q         <= ex_MemSignExt;
                        msel_q         <= ex_MemRegSel;
                        regw_q         <= ex_RegWriteSel;
                        size_q         <= ex_MemSize;
                        addr_q         <= ex_AluResult;
                        dest_q         <= ex_RegDest;
                        ext_Rd         <= ex_MemRead;
                        ext_Wr         <= ~ex_MemRead;
                        ext_Addr       <= {ex_AluResult[31:2], 2'b00};
                        ext_WrData     <= st_data;
                        ext_ByteEn     <= st_be;
                        me_RegWriteSel <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (ext_Ack) begin
                        state_q        <= ST_IDLE;
                        ext_Rd         <= 1'b0;
                        ext_Wr         <= 1'b0;
                        me_ByData      <= addr_q;
                        me_MemRegSel   <= msel_q;
                        me_RegWriteSel <= regw_q;
                        me_RegDest     <= dest_q;
                        if (ld_q) begin
                            me_ExtMemRdData <= ld_data;
                        end
                    end else if (timeout) begin
                        state_q        <= ST_IDLE;
                        ext_Rd         <= 1'b0;
                        ext_Wr         <= 1'b0;
                        me_BusErr      <= 1'b1;
                        me_RegWriteSel <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + TIMEOUT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expectations,
// a negedge monitor pops and compares on bus completions and WB events.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_Valid = 1'b0;
    logic [31:0] ex_AluResult = '0;
    logic [31:0] ex_StoreData = '0;
    logic        ex_MemRead = 1'b0;
    logic        ex_MemWrite = 1'b0;
    logic [1:0]  ex_MemSize = '0;
    logic        ex_MemSignExt = 1'b0;
    logic        ex_MemRegSel = 1'b0;
    logic        ex_RegWriteSel = 1'b0;
    logic [4:0]  ex_RegDest = '0;
    logic [31:0] ext_Addr, ext_WrData;
    logic [3:0]  ext_ByteEn;
    logic        ext_Rd, ext_Wr;
    logic        ext_Ack = 1'b0;
    logic [31:0] ext_RdData = '0;
    logic        me_Stall;
    logic [31:0] me_ExtMemRdData, me_ByData;
    logic        me_MemRegSel, me_RegWriteSel;
    logic [4:0]  me_RegDest;
    logic        me_AlignErr, me_BusErr;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_Valid(ex_Valid), .ex_AluResult(ex_AluResult),
        .ex_StoreData(ex_StoreData), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemSize(ex_MemSize),
        .ex_MemSignExt(ex_MemSignExt), .ex_MemRegSel(ex_MemRegSel),
        .ex_RegWriteSel(ex_RegWriteSel), .ex_RegDest(ex_RegDest),
        .ext_Addr(ext_Addr), .ext_WrData(ext_WrData),
        .ext_ByteEn(ext_ByteEn), .ext_Rd(ext_Rd), .ext_Wr(ext_Wr),
        .ext_Ack(ext_Ack), .ext_RdData(ext_RdData),
        .me_Stall(me_Stall), .me_ExtMemRdData(me_ExtMemRdData),
        .me_ByData(me_ByData), .me_MemRegSel(me_MemRegSel),
        .me_RegWriteSel(me_RegWriteSel), .me_RegDest(me_RegDest),
        .me_AlignErr(me_AlignErr), .me_BusErr(me_BusErr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr, sd, rdata;
        int          ack;
        logic        regwr;
        logic [4:0]  dest;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_ld;
        logic        e_align;
    } vec_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        rd, wr;
    } bus_t;

    typedef struct {
        logic [31:0] by, ld;
        logic [4:0]  dest;
        logic        msel, align, bus;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    vec_t vt[$];
    logic [31:0] last_ld = '0;

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [1:0] size,
        input logic sext, input logic [31:0] addr, input logic [31:0] sd,
        input logic [31:0] rdata, input int ack, input logic regwr,
        input logic [4:0] dest, input logic [31:0] e_addr,
        input logic [31:0] e_wdata, input logic [3:0] e_be,
        input logic [31:0] e_ld, input logic e_align);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.sext = sext;
        v.addr = addr; v.sd = sd; v.rdata = rdata; v.ack = ack;
        v.regwr = regwr; v.dest = dest; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_be = e_be; v.e_ld = e_ld;
        v.e_align = e_align;
        return v;
    endfunction

    // Monitor: bus completion and WB-visible events are checked against queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if ((ext_Rd | ext_Wr) && ext_Ack) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("ext_Addr", ext_Addr, b.addr);
                    chk("ext_ByteEn", {28'd0, ext_ByteEn}, {28'd0, b.be});
                    chk("ext_RdWr", {30'd0, ext_Rd, ext_Wr}, {30'd0, b.rd, b.wr});
                    if (b.wr) chk("ext_WrData", ext_WrData, b.wdata);
                end
            end
            if (me_RegWriteSel | me_AlignErr | me_BusErr) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("err_flags", {29'd0, me_AlignErr, me_BusErr, me_RegWriteSel},
                        {29'd0, w.align, w.bus, ~(w.align | w.bus)});
                    if (!(w.align | w.bus)) begin
                        chk("me_ByData", me_ByData, w.by);
                        chk("me_ExtMemRdData", me_ExtMemRdData, w.ld);
                        chk("me_RegDest", {27'd0, me_RegDest}, {27'd0, w.dest});
                        chk("me_MemRegSel", {31'd0, me_MemRegSel}, {31'd0, w.msel});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int   stalls = 0;
        int   strobes = 0;
        int   exp_stall;
        bit   done = 0;
        bit   mem;
        bus_t b;
        wb_t  w;
        mem = v.rd | v.wr;
        w.by = v.addr; w.ld = last_ld; w.dest = v.dest;
        w.msel = v.rd; w.align = 1'b0; w.bus = 1'b0;
        if (v.e_align) begin
            w.align = 1'b1;
            wb_q.push_back(w);
        end else if (mem && v.ack < 0) begin
            w.bus = 1'b1;
            wb_q.push_back(w);
        end else begin
            if (mem) begin
                b.addr = v.e_addr; b.wdata = v.e_wdata; b.be = v.e_be;
                b.rd = v.rd; b.wr = v.wr & ~v.rd;
                bus_q.push_back(b);
                if (v.rd) begin
                    last_ld = v.e_ld;
                    w.ld = v.e_ld;
                end
            end
            if (v.regwr) wb_q.push_back(w);
        end
        exp_stall = (v.e_align || !mem) ? 0 : (v.ack < 0 ? 16 : v.ack + 1);
        ex_Valid = 1'b1; ex_AluResult = v.addr; ex_StoreData = v.sd;
        ex_MemRead = v.rd; ex_MemWrite = v.wr; ex_MemSize = v.size;
        ex_MemSignExt = v.sext; ex_MemRegSel = v.rd;
        ex_RegWriteSel = v.regwr; ex_RegDest = v.dest;
        #1;
        stalls += int'(me_Stall);
        @(posedge clk);
        #1;
        if (mem && !v.e_align) begin
            for (int c = 0; c < 40 && !done; c++) begin
                if (c == v.ack) begin
                    ext_Ack = 1'b1;
                    ext_RdData = v.rdata;
                end
                #1;
                stalls += int'(me_Stall);
                strobes += int'(ext_Rd | ext_Wr);
                @(posedge clk);
                #1;
                ext_Ack = 1'b0;
                if (c == v.ack || me_BusErr) done = 1;
            end
            chk("access_done", {31'd0, done}, 32'd1);
            chk("me_RegWriteSel", {31'd0, me_RegWriteSel},
                {31'd0, (v.ack >= 0) ? v.regwr : 1'b0});
            chk("strobe_cycles", strobes, (v.ack >= 0) ? v.ack + 1 : 15);
        end
        ex_Valid = 1'b0;
        #1;
        chk("strobes_idle", {30'd0, ext_Rd, ext_Wr}, 32'd0);
        chk("stall_cycles", stalls, exp_stall);
        chk("stall_released", {31'd0, me_Stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //     rd wr sz    sx addr          sd            rdata        ack rw dst e_addr        e_wdata       be       e_ld          al
        vt.push_back(mk(0, 0, 2'd2, 0, 32'h0000_1234, 32'h0,        32'h0,        0, 1, 5,  32'h0,        32'h0,        4'b0000, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 3, 1, 8,  32'h0000_0100, 32'h0,        4'b1000, 32'hFFFF_FF80, 0));
        vt.push_back(mk(0, 1, 2'd1, 0, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        1, 0, 0,  32'h0000_0100, 32'hABCD_ABCD, 4'b1100, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd2, 0, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 9,  32'h0,        32'h0,        4'b0000, 32'h0,        1));
        vt.push_back(mk(1, 0, 2'd1, 0, 32'h0000_0106, 32'h0,        32'h8765_4321, 0, 1, 10, 32'h0000_0104, 32'h0,        4'b1100, 32'h0000_8765, 0));
        vt.push_back(mk(1, 0, 2'd1, 1, 32'h0000_0108, 32'h0,        32'h1234_F00D, 2, 1, 11, 32'h0000_0108, 32'h0,        4'b0011, 32'hFFFF_F00D, 0));
        vt.push_back(mk(1, 0, 2'd0, 0, 32'h0000_0101, 32'h0,        32'h0000_A500, 1, 1, 12, 32'h0000_0100, 32'h0,        4'b0010, 32'h0000_00A5, 0));
        vt.push_back(mk(0, 1, 2'd0, 0, 32'h0000_0201, 32'h1234_565A, 32'h0,        0, 0, 0,  32'h0000_0200, 32'h5A5A_5A5A, 4'b0010, 32'h0,        0));
        vt.push_back(mk(0, 1, 2'd2, 0, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0,        2, 0, 0,  32'h0000_0204, 32'hDEAD_BEEF, 4'b1111, 32'h0,        0));
        vt.push_back(mk(1, 1, 2'd3, 1, 32'h0000_010C, 32'h0,        32'hCAFE_BABE, 1, 1, 13, 32'h0000_010C, 32'h0,        4'b1111, 32'hCAFE_BABE, 0));
        vt.push_back(mk(0, 1, 2'd1, 0, 32'h0000_0103, 32'h0000_1111, 32'h0,        0, 0, 0,  32'h0,        32'h0,        4'b0000, 32'h0,        1));
        vt.push_back(mk(0, 0, 2'd2, 0, 32'h0000_55AA, 32'h0,        32'h0,        0, 1, 3,  32'h0,        32'h0,        4'b0000, 32'h0,        0));
        vt.push_back(mk(1, 0, 2'd2, 0, 32'h0000_0200, 32'h0,        32'h0,        -1, 1, 14, 32'h0000_0200, 32'h0,       4'b1111, 32'h0,        0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ext_Addr", ext_Addr, 32'h0);
        chk("rst_ext_WrData", ext_WrData, 32'h0);
        chk("rst_ext_ctl", {26'd0, ext_ByteEn, ext_Rd, ext_Wr}, 32'h0);
        chk("rst_me_rd", me_ExtMemRdData, 32'h0);
        chk("rst_me_by", me_ByData, 32'h0);
        chk("rst_me_ctl", {23'd0, me_Stall, me_MemRegSel, me_RegWriteSel,
                           me_RegDest, me_AlignErr, me_BusErr}, 32'h0);
        reset_n = 1'b1;
        tick();

        foreach (vt[i]) run_vec(vt[i]);
        repeat (2) tick();

        // Reset while a load is waiting for its ack, then a stale ack.
        ex_Valid = 1'b1; ex_AluResult = 32'h0000_0300; ex_MemRead = 1'b1;
        ex_MemWrite = 1'b0; ex_MemSize = 2'd2; ex_RegWriteSel = 1'b1;
        ex_RegDest = 5'd7; ex_MemRegSel = 1'b1;
        tick();
        tick();
        chk("pre_rst_ext_Rd", {31'd0, ext_Rd}, 32'd1);
        #2;
        reset_n = 1'b0;
        ex_Valid = 1'b0;
        #1;
        chk("async_ext_Rd", {31'd0, ext_Rd}, 32'd0);
        chk("async_ext_Addr", ext_Addr, 32'h0);
        chk("async_stall", {31'd0, me_Stall}, 32'd0);
        chk("async_me_by", me_ByData, 32'h0);
        chk("async_me_rd", me_ExtMemRdData, 32'h0);
        chk("async_me_dest", {27'd0, me_RegDest}, 32'h0);
        ext_Ack = 1'b1;
        ext_RdData = 32'hFFFF_FFFF;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        ext_Ack = 1'b0;
        chk("late_ack_rd", me_ExtMemRdData, 32'h0);
        chk("late_ack_ctl", {29'd0, ext_Rd, ext_Wr, me_RegWriteSel}, 32'h0);
        tick();
        chk("late_ack_stall", {31'd0, me_Stall}, 32'd0);

        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("wb_q_empty", wb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
